// File: rtl/eth_tx_phy.sv
// 10BASE-T Manchester transmitter: preamble/SFD insertion, LSB-first byte
// serialization, TP_IDL end-of-frame marker, inter-frame gap and normal
// link pulses while idle. One clk cycle is one Manchester half-bit.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | line low, waiting for a frame or for the link pulse timer
// NLP      | normal link pulse, line high for NLP_WIDTH cycles
// PREAMBLE | 7 x 0x55 followed by SFD 0xD5
// DATA     | frame bytes from upstream, one byte every 16 cycles
// TPIDL    | end-of-frame high level for TPIDL_CYCLES
// GAP      | enforced low inter-frame gap of IFG_CYCLES
module eth_tx_phy #(
    parameter int NLP_PERIOD   = 320000,
    parameter int NLP_WIDTH    = 2,
    parameter int TPIDL_CYCLES = 6,
    parameter int IFG_CYCLES   = 192
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       underrun
);

    localparam int NLP_W   = (NLP_PERIOD > 1) ? $clog2(NLP_PERIOD) : 1;
    localparam int TMR_MAX = (IFG_CYCLES > TPIDL_CYCLES)
                           ? ((IFG_CYCLES > NLP_WIDTH) ? IFG_CYCLES : NLP_WIDTH)
                           : ((TPIDL_CYCLES > NLP_WIDTH) ? TPIDL_CYCLES : NLP_WIDTH);
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [NLP_W-1:0] NLP_TC   = NLP_W'(NLP_PERIOD - 1);
    localparam logic [TMR_W-1:0] NLP_LD   = TMR_W'(NLP_WIDTH - 1);
    localparam logic [TMR_W-1:0] TPIDL_LD = TMR_W'(TPIDL_CYCLES - 1);
    localparam logic [TMR_W-1:0] IFG_LD   = TMR_W'(IFG_CYCLES - 1);

    localparam logic [7:0] PRE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_NLP      = 3'd1,
        S_PREAMBLE = 3'd2,
        S_DATA     = 3'd3,
        S_TPIDL    = 3'd4,
        S_GAP      = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       hb_q, hb_d;       // half-bit index within the current byte
    logic [2:0]       pre_q, pre_d;     // preamble byte index, 7 = SFD
    logic [7:0]       sr_q, sr_d;       // byte being serialized
    logic             last_q, last_d;   // current data byte closes the frame
    logic [TMR_W-1:0] tmr_q, tmr_d;     // down-counter for NLP/TPIDL/GAP
    logic [NLP_W-1:0] nlp_q, nlp_d;     // idle time since last pulse or frame
    logic             tx_q, tx_d;
    logic             byte_end;
    logic             sel_bit;

    // Next-state, counter and handshake logic.
    always_comb begin
        state_d  = state_q;
        hb_d     = hb_q;
        pre_d    = pre_q;
        sr_d     = sr_q;
        last_d   = last_q;
        tmr_d    = tmr_q;
        nlp_d    = nlp_q;
        in_ready = 1'b0;
        underrun = 1'b0;
        byte_end = (hb_q == 4'd15);

        case (state_q)
            S_IDLE: begin
                // A due link pulse takes priority over a waiting frame.
                if (nlp_q == NLP_TC) begin
                    state_d = S_NLP;
                    tmr_d   = NLP_LD;
                end else begin
                    nlp_d = nlp_q + NLP_W'(1);
                    if (in_valid) begin
                        state_d = S_PREAMBLE;
                        hb_d    = 4'd0;
                        pre_d   = 3'd0;
                        sr_d    = PRE_BYTE;
                        last_d  = 1'b0;
                    end
                end
            end
            S_NLP: begin
                if (tmr_q == '0) begin
                    state_d = S_IDLE;
                    nlp_d   = '0;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_PREAMBLE, S_DATA: begin
                hb_d = hb_q + 4'd1;
                if (byte_end) begin
                    if (state_q == S_PREAMBLE && pre_q != 3'd7) begin
                        pre_d = pre_q + 3'd1;
                        sr_d  = (pre_q == 3'd6) ? SFD_BYTE : PRE_BYTE;
                    end else if (state_q == S_DATA && last_q) begin
                        state_d = S_TPIDL;
                        tmr_d   = TPIDL_LD;
                    end else begin
                        in_ready = 1'b1;
                        if (in_valid) begin
                            state_d = S_DATA;
                            sr_d    = in_data;
                            last_d  = in_last;
                        end else begin
                            // Starved mid-frame: close the frame early.
                            underrun = 1'b1;
                            state_d  = S_TPIDL;
                            tmr_d    = TPIDL_LD;
                        end
                    end
                end
            end
            S_TPIDL: begin
                if (tmr_q == '0) begin
                    state_d = S_GAP;
                    tmr_d   = IFG_LD;
                    nlp_d   = '0;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_GAP: begin
                if (nlp_q != NLP_TC) begin
                    nlp_d = nlp_q + NLP_W'(1);
                end
                if (tmr_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Line level for the next cycle: Manchester half-bit or fixed level.
    always_comb begin
        sel_bit = sr_d[hb_d[3:1]];
        tx_d    = 1'b0;
        case (state_d)
            S_PREAMBLE, S_DATA: tx_d = hb_d[0] ? sel_bit : ~sel_bit;
            S_NLP, S_TPIDL:     tx_d = 1'b1;
            default:            tx_d = 1'b0;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hb_q    <= '0;
            pre_q   <= '0;
            sr_q    <= '0;
            last_q  <= 1'b0;
            tmr_q   <= '0;
            nlp_q   <= '0;
            tx_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hb_q    <= hb_d;
            pre_q   <= pre_d;
            sr_q    <= sr_d;
            last_q  <= last_d;
            tmr_q   <= tmr_d;
            nlp_q   <= nlp_d;
            tx_q    <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_eth_tx_phy.sv
// Directed bench for eth_tx_phy: single frame, back-to-back bytes, underrun,
// link pulse timing, pulse/frame collision and reset during data.
module tb_eth_tx_phy;

    localparam int P = 1500;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic       underrun;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] frm [0:7];

    eth_tx_phy #(
        .NLP_PERIOD  (P),
        .NLP_WIDTH   (2),
        .TPIDL_CYCLES(6),
        .IFG_CYCLES  (192)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_last (in_last),
        .in_ready(in_ready),
        .tx      (tx),
        .busy    (busy),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Preamble/SFD half-bit at index 0..127: 0x55 gives 0,1,1,0 repeating;
    // the SFD's two final 1 bits give 0,1,0,1 at 124..127.
    function automatic logic pre_exp(input int idx);
        if (idx >= 124) return logic'(idx % 2);
        case (idx % 4)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic do_reset(input string tag);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        step();
        rst = 1'b0;
        #1;
        check_val({tag, "/tx"},       tx,       32'd0);
        check_val({tag, "/busy"},     busy,     32'd0);
        check_val({tag, "/in_ready"}, in_ready, 32'd0);
        check_val({tag, "/underrun"}, underrun, 32'd0);
    endtask

    // Starts a frame in the current (idle) cycle 0 and follows it to IDLE.
    // n bytes are accepted; trunc drops in_valid after them instead of in_last.
    task automatic run_frame(input string tag, input int n, input bit trunc);
        int e;
        e = 128 + 16 * n;
        for (int i = 0; i <= e + 199; i++) begin
            int   k;
            int   h;
            logic bv;
            logic exp_tx;
            logic exp_rdy;
            if (i <= 128 + 16 * (n - 1)) begin
                k        = (i <= 128) ? 0 : (i - 129) / 16 + 1;
                in_valid = 1'b1;
                in_data  = frm[k];
                in_last  = !trunc && (k == n - 1);
            end else begin
                in_valid = 1'b0;
                in_data  = 8'h00;
                in_last  = 1'b0;
            end
            #1;
            if (i == 0) begin
                exp_tx = 1'b0;
            end else if (i <= 128) begin
                exp_tx = pre_exp(i - 1);
            end else if (i <= e) begin
                k      = (i - 129) / 16;
                h      = (i - 129) % 16;
                bv     = frm[k][h / 2];
                exp_tx = (h % 2 == 1) ? bv : ~bv;
            end else if (i <= e + 6) begin
                exp_tx = 1'b1;
            end else begin
                exp_tx = 1'b0;
            end
            exp_rdy = (i >= 128) && (i <= e) && ((i - 128) % 16 == 0) && ((i < e) || trunc);
            check_val($sformatf("%s/tx@%0d", tag, i),       tx,       32'(exp_tx));
            check_val($sformatf("%s/rdy@%0d", tag, i),      in_ready, 32'(exp_rdy));
            check_val($sformatf("%s/undr@%0d", tag, i),     underrun, 32'(trunc && (i == e)));
            check_val($sformatf("%s/busy@%0d", tag, i),     busy,     32'((i > 0) && (i <= e + 198)));
            step();
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        step();

        // Single byte 0xA5 with in_last.
        do_reset("rst_single");
        frm[0] = 8'hA5;
        run_frame("single", 1, 1'b0);

        // Three back-to-back bytes.
        do_reset("rst_b2b");
        frm[0] = 8'h01;
        frm[1] = 8'h02;
        frm[2] = 8'h03;
        run_frame("b2b", 3, 1'b0);

        // Underrun after the first byte.
        do_reset("rst_undr");
        frm[0] = 8'h0F;
        run_frame("undr", 1, 1'b1);

        // Idle link pulses: high at P, P+1, then again 2P+2, 2P+3.
        do_reset("rst_nlp");
        for (int k = 0; k <= 2 * P + 4; k++) begin
            logic exp_p;
            exp_p = (k == P) || (k == P + 1) || (k == 2 * P + 2) || (k == 2 * P + 3);
            #1;
            check_val($sformatf("nlp/tx@%0d", k),   tx,   32'(exp_p));
            check_val($sformatf("nlp/busy@%0d", k), busy, 32'(exp_p));
            step();
        end

        // in_valid rises in the cycle the pulse is due: pulse first, byte kept.
        do_reset("rst_col");
        for (int k = 0; k < P - 1; k++) step();
        frm[0]   = 8'h3C;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        in_last  = 1'b1;
        #1;
        check_val("col/tx_due",   tx,   32'd0);
        check_val("col/busy_due", busy, 32'd0);
        step();
        #1;
        check_val("col/tx_p0",   tx,   32'd1);
        check_val("col/busy_p0", busy, 32'd1);
        step();
        #1;
        check_val("col/tx_p1",   tx,   32'd1);
        check_val("col/busy_p1", busy, 32'd1);
        step();
        run_frame("col", 1, 1'b0);

        // Reset during DATA, then a normal frame with full preamble.
        do_reset("rst_mid");
        for (int i = 0; i < 135; i++) begin
            in_valid = (i <= 128);
            in_data  = 8'hFF;
            in_last  = 1'b0;
            step();
        end
        #1;
        check_val("mid/tx_before",   tx,   32'd0);
        check_val("mid/busy_before", busy, 32'd1);
        rst      = 1'b1;
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;
        check_val("mid/tx_after",       tx,       32'd0);
        check_val("mid/busy_after",     busy,     32'd0);
        check_val("mid/in_ready_after", in_ready, 32'd0);
        check_val("mid/underrun_after", underrun, 32'd0);
        frm[0] = 8'hA5;
        run_frame("post_rst", 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
